merge_layer_n: RTL and testbench

MERGE_LAYER_N -- requirements
Module: merge_layer_n

---
 rtl/merge_pkg.sv | 14 +
 rtl/merge_compare.sv | 29 ++
 rtl/merge_layer_n.sv | 117 +++++++++++
 tb/tb_merge_layer_n.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared definitions for the two-run merge layer: FSM state encoding and
// merge-direction constants.
package merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DONE  = 2'd2
  } merge_state_t;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

endpackage

// File: rtl/merge_compare.sv
// Head-of-run selector: decides whether the next merged element comes from
// run B. An exhausted run never wins, and ties always go to A so the merge is stable.
module merge_compare
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  order,
  input  logic                  a_done,
  input  logic                  b_done,
  output logic                  pick_b
);

  always_comb begin
    pick_b = 1'b0;
    if (b_done) begin
      pick_b = 1'b0;
    end else if (a_done) begin
      pick_b = 1'b1;
    end else if (order == ORDER_DESC) begin
      pick_b = (a < b);
    end else begin
      pick_b = (a > b);
    end
  end

endmodule

// File: rtl/merge_layer_n.sv
// Merges two sorted runs of RUN_LEN elements into one 2*RUN_LEN stream with
// valid/ready handshake. Runs are captured on start, then drained one element per transfer.
module merge_layer_n
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RUN_LEN    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          order,
  input  logic [RUN_LEN*DATA_WIDTH-1:0] run_a,
  input  logic [RUN_LEN*DATA_WIDTH-1:0] run_b,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_src,
  output logic                          out_last,
  output logic                          done
);

  localparam int PTR_W = $clog2(RUN_LEN + 1);
  localparam logic [PTR_W-1:0] RUN_END  = PTR_W'(RUN_LEN);
  localparam logic [PTR_W:0]   LAST_SUM = (PTR_W + 1)'(2 * RUN_LEN - 1);

  merge_state_t          state;
  logic                  order_q;
  logic [PTR_W-1:0]      ptr_a;
  logic [PTR_W-1:0]      ptr_b;
  logic [DATA_WIDTH-1:0] buf_a [RUN_LEN];
  logic [DATA_WIDTH-1:0] buf_b [RUN_LEN];

  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  a_done;
  logic                  b_done;
  logic                  pick_b;
  logic                  merging;
  logic                  is_last;
  logic                  xfer;
  logic [PTR_W:0]        ptr_sum;

  // Exhausted pointers (== RUN_LEN) match no slot and read as zero.
  always_comb begin
    head_a = '0;
    head_b = '0;
    for (int i = 0; i < RUN_LEN; i++) begin
      if (ptr_a == PTR_W'(i)) head_a = buf_a[i];
      if (ptr_b == PTR_W'(i)) head_b = buf_b[i];
    end
  end

  assign a_done  = (ptr_a == RUN_END);
  assign b_done  = (ptr_b == RUN_END);
  assign merging = (state == ST_MERGE);
  assign ptr_sum = {1'b0, ptr_a} + {1'b0, ptr_b};
  assign is_last = merging && (ptr_sum == LAST_SUM);
  assign xfer    = merging && out_ready;

  merge_compare #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_compare (
    .a      (head_a),
    .b      (head_b),
    .order  (order_q),
    .a_done (a_done),
    .b_done (b_done),
    .pick_b (pick_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      order_q <= ORDER_ASC;
      ptr_a   <= '0;
      ptr_b   <= '0;
      for (int i = 0; i < RUN_LEN; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            order_q <= order;
            ptr_a   <= '0;
            ptr_b   <= '0;
            for (int i = 0; i < RUN_LEN; i++) begin
              buf_a[i] <= run_a[i*DATA_WIDTH +: DATA_WIDTH];
              buf_b[i] <= run_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
            state <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          if (xfer) begin
            if (pick_b) ptr_b <= ptr_b + PTR_W'(1);
            else        ptr_a <= ptr_a + PTR_W'(1);
            if (is_last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = merging;
  assign out_data  = merging ? (pick_b ? head_b : head_a) : '0;
  assign out_src   = merging && pick_b;
  assign out_last  = is_last;

endmodule

// File: tb/tb_merge_layer_n.sv
// Directed bench for merge_layer_n (DATA_WIDTH=8, RUN_LEN=4) with hand-computed
// expected streams; outputs are sampled on the falling edge.
module tb_merge_layer_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        order;
  logic [31:0] run_a;
  logic [31:0] run_b;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_src;
  logic        out_last;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  merge_layer_n #(.DATA_WIDTH(8), .RUN_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .order     (order),
    .run_a     (run_a),
    .run_b     (run_b),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"}, 32'(out_valid), 32'd0);
    check({tag, " data"},  32'(out_data),  32'd0);
    check({tag, " src"},   32'(out_src),   32'd0);
    check({tag, " last"},  32'(out_last),  32'd0);
    check({tag, " busy"},  32'(busy),      32'd0);
    check({tag, " done"},  32'(done),      32'd0);
  endtask

  task automatic check_elem(input string tag, input int i, input logic [63:0] exp_d, input logic [7:0] exp_s);
    check($sformatf("%s e%0d valid", tag, i), 32'(out_valid), 32'd1);
    check($sformatf("%s e%0d data", tag, i),  32'(out_data),  32'(exp_d[i*8 +: 8]));
    check($sformatf("%s e%0d src", tag, i),   32'(out_src),   32'(exp_s[i]));
    check($sformatf("%s e%0d last", tag, i),  32'(out_last),  32'(i == 7));
  endtask

  // Called at a falling edge; returns at the falling edge where element 0 is shown.
  task automatic launch(input logic ord, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    order = ord;
    run_a = a;
    run_b = b;
    @(negedge clk);
    start = 1'b0;
    run_a = 32'hA5A5_A5A5;
    run_b = 32'h5A5A_5A5A;
    order = ~ord;
  endtask

  // stall_idx: hold ready low 3 cycles at that element; poke_idx: pulse start there;
  // poke_done: pulse start in the DONE cycle; rst_idx: assert reset at that element.
  task automatic run_stream(input string tag, input logic ord, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_d, input logic [7:0] exp_s,
                            input int stall_idx, input int poke_idx, input bit poke_done, input int rst_idx);
    launch(ord, a, b);
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_elem(tag, i, exp_d, exp_s);
      if (i == rst_idx) begin
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_idle_outputs({tag, " post-rst"});
        return;
      end
      if (i == stall_idx) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_elem({tag, " stall"}, i, exp_d, exp_s);
        end
        out_ready = 1'b1;
      end
      if (i == poke_idx) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done valid"}, 32'(out_valid), 32'd0);
    check({tag, " done busy"}, 32'(busy), 32'd1);
    if (poke_done) begin
      start = 1'b1;
      run_a = pack4(8'd0, 8'd0, 8'd0, 8'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs({tag, " idle"});
  endtask

  logic [63:0] seq_1to8;

  initial begin
    seq_1to8  = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    rst       = 1'b1;
    start     = 1'b0;
    order     = 1'b0;
    run_a     = '0;
    run_b     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_stream("asc", 1'b0, pack4(1, 3, 5, 7), pack4(2, 4, 6, 8),
               seq_1to8, 8'b1010_1010, -1, -1, 1'b0, -1);

    run_stream("ties", 1'b0, pack4(2, 2, 5, 9), pack4(2, 3, 3, 9),
               {8'd9, 8'd9, 8'd5, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2}, 8'b1001_1100, -1, -1, 1'b0, -1);

    run_stream("desc", 1'b1, pack4(9, 6, 3, 0), pack4(8, 7, 1, 1),
               {8'd0, 8'd1, 8'd1, 8'd3, 8'd6, 8'd7, 8'd8, 8'd9}, 8'b0110_0110, -1, -1, 1'b0, -1);

    run_stream("exhaust", 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8),
               seq_1to8, 8'b1111_0000, -1, -1, 1'b0, -1);

    run_stream("bp", 1'b0, pack4(1, 3, 5, 7), pack4(2, 4, 6, 8),
               seq_1to8, 8'b1010_1010, 2, -1, 1'b0, -1);

    run_stream("poke", 1'b0, pack4(2, 2, 5, 9), pack4(2, 3, 3, 9),
               {8'd9, 8'd9, 8'd5, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2}, 8'b1001_1100, -1, 4, 1'b1, -1);

    run_stream("rst", 1'b0, pack4(2, 2, 5, 9), pack4(2, 3, 3, 9),
               {8'd9, 8'd9, 8'd5, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2}, 8'b1001_1100, -1, -1, 1'b0, 3);

    run_stream("fresh", 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8),
               seq_1to8, 8'b1111_0000, -1, -1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
